// File: rtl/cache_repair_arbiter_if.sv
// Client-side repair requests plus the shared backing-memory port, bundled as one interface.
// Latency: none, wires only.
// Backpressure: memory accepts through mem_rready/mem_wready; clients hold their requests until repair_resolved.
interface cache_repair_arbiter_if #(
    parameter int LINE_BITS = 256,
    parameter int MASK_BITS = 32
);
    // Client side: index 0 is the I-cache, index 1 is the D-cache
    logic [1:0]                 read_repair_request;
    logic [1:0]                 write_miss_repair;
    logic [1:0][31:0]           missed_addr;
    logic [1:0][31:0]           wb_addr;
    logic [1:0][LINE_BITS-1:0]  wb_data;
    logic [1:0][MASK_BITS-1:0]  wb_mask;
    logic [1:0]                 repair_resolved;
    logic [LINE_BITS-1:0]       fill_data;

    // Backing-memory side
    logic                       mem_raddr_valid;
    logic [31:0]                mem_raddr;
    logic                       mem_rready;
    logic [LINE_BITS-1:0]       mem_rdata;
    logic                       mem_rdata_valid;
    logic                       mem_waddr_valid;
    logic [31:0]                mem_waddr;
    logic [LINE_BITS-1:0]       mem_wdata;
    logic [MASK_BITS-1:0]       mem_wmask;
    logic                       mem_wready;

    // Status
    logic [1:0]                 grant;
    logic                       timeout_err;

    // Arbiter view
    modport master (
        input  read_repair_request, write_miss_repair, missed_addr, wb_addr, wb_data, wb_mask,
        input  mem_rready, mem_rdata, mem_rdata_valid, mem_wready,
        output repair_resolved, fill_data,
        output mem_raddr_valid, mem_raddr, mem_waddr_valid, mem_waddr, mem_wdata, mem_wmask,
        output grant, timeout_err
    );

    // Environment view: the two clients and the memory
    modport slave (
        output read_repair_request, write_miss_repair, missed_addr, wb_addr, wb_data, wb_mask,
        output mem_rready, mem_rdata, mem_rdata_valid, mem_wready,
        input  repair_resolved, fill_data,
        input  mem_raddr_valid, mem_raddr, mem_waddr_valid, mem_waddr, mem_wdata, mem_wmask,
        input  grant, timeout_err
    );
endinterface

// File: rtl/cache_repair_arbiter.sv
// Round-robin arbiter that shares one backing-memory port between the I-cache and D-cache repair engines.
// Latency: request to repair_resolved is 4 cycles for a fill and 5 for a writeback+fill, with zero-wait memory.
// Backpressure: mem_*_valid and its payload stay constant until mem_*ready; a silent memory trips the watchdog.
module cache_repair_arbiter #(
    parameter int LINE_BITS = 256,
    parameter int MASK_BITS = 32,
    parameter int TIMEOUT   = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    cache_repair_arbiter_if.master  bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    // Last watchdog value before the timeout fires: the counter reads 0 in the first RD_WAIT cycle
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] RD_REQ  = 3'd2;
    localparam logic [2:0] RD_WAIT = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]             state_q;
    logic                   rr_ptr_q;
    logic [1:0]             grant_q;
    logic [1:0]             resolved_q;
    logic [LINE_BITS-1:0]   fill_q;
    logic                   raddr_vld_q;
    logic                   waddr_vld_q;
    logic                   timeout_q;
    logic [WD_W-1:0]        wd_q;
    logic [31:0]            rd_addr_q;
    logic [31:0]            wr_addr_q;
    logic [LINE_BITS-1:0]   wr_data_q;
    logic [MASK_BITS-1:0]   wr_mask_q;

    logic [1:0]             req;
    logic                   any_req;
    logic                   pick;

    // Choose the preferred client if it is asking, otherwise the other one
    always_comb begin
        req     = bus.read_repair_request | bus.write_miss_repair;
        any_req = |req;
        pick    = rr_ptr_q;
        if (!req[rr_ptr_q]) begin
            pick = ~rr_ptr_q;
        end
    end

    // Transaction sequencer: latch the winner in IDLE, then walk writeback, read, wait, resolve
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            grant_q     <= '0;
            resolved_q  <= '0;
            fill_q      <= '0;
            raddr_vld_q <= 1'b0;
            waddr_vld_q <= 1'b0;
            timeout_q   <= 1'b0;
            wd_q        <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_mask_q   <= '0;
        end else begin
            resolved_q <= '0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q   <= pick ? 2'b10 : 2'b01;
                        // Line-align once here so the memory payload never changes while valid
                        rd_addr_q <= bus.missed_addr[pick] & 32'hFFFF_FFE0;
                        wr_addr_q <= bus.wb_addr[pick] & 32'hFFFF_FFE0;
                        wr_data_q <= bus.wb_data[pick];
                        wr_mask_q <= bus.wb_mask[pick];
                        if (bus.write_miss_repair[pick]) begin
                            waddr_vld_q <= 1'b1;
                            state_q     <= WR_REQ;
                        end else begin
                            raddr_vld_q <= 1'b1;
                            state_q     <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (bus.mem_wready) begin
                        waddr_vld_q <= 1'b0;
                        raddr_vld_q <= 1'b1;
                        state_q     <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (bus.mem_rready) begin
                        raddr_vld_q <= 1'b0;
                        wd_q        <= '0;
                        state_q     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.mem_rdata_valid) begin
                        fill_q     <= bus.mem_rdata;
                        resolved_q <= grant_q;
                        state_q    <= DONE;
                    end else if (wd_q == WD_LAST) begin
                        // Memory never answered: resolve with an empty line and flag it until reset
                        timeout_q  <= 1'b1;
                        fill_q     <= '0;
                        resolved_q <= grant_q;
                        state_q    <= DONE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                DONE: begin
                    // Hand priority to whichever client did not just finish
                    rr_ptr_q <= ~grant_q[1];
                    grant_q  <= '0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.repair_resolved = resolved_q;
    assign bus.fill_data       = fill_q;
    assign bus.mem_raddr_valid = raddr_vld_q;
    assign bus.mem_raddr       = rd_addr_q;
    assign bus.mem_waddr_valid = waddr_vld_q;
    assign bus.mem_waddr       = wr_addr_q;
    assign bus.mem_wdata       = wr_data_q;
    assign bus.mem_wmask       = wr_mask_q;
    assign bus.grant           = grant_q;
    assign bus.timeout_err     = timeout_q;

endmodule

// File: doc/cache_repair_arbiter.md
Name: cache_repair_arbiter

Overview:
Shares the single backing-memory port between two cache controllers: client 0 = I-cache, client 1 = D-cache. Each client raises a read-repair (line fill) or write-miss-repair (dirty-line writeback followed by fill). The arbiter grants one client at a time with round-robin priority, drives memory read/write requests, returns the filled line, and pulses repair_resolved to the granted client. A watchdog counter flags memory that never answers.

Parameters:
LINE_BITS, 256, cache line width in bits
MASK_BITS, 32, byte-enable width (LINE_BITS/8)
TIMEOUT, 1023, max cycles in RD_WAIT before error; counter width is $clog2(TIMEOUT+1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
read_repair_request  input  2  per-client fill request, level, held until repair_resolved
write_miss_repair  input  2  per-client writeback+fill request, level, held until repair_resolved
missed_addr  input  2x32  per-client line address; bits [4:0] ignored
wb_addr  input  2x32  per-client victim line address for writeback
wb_data  input  2xLINE_BITS  per-client victim line data
wb_mask  input  2xMASK_BITS  per-client byte enables
repair_resolved  output  2  one-cycle pulse to the granted client on completion
fill_data  output  LINE_BITS  line returned to clients; valid when repair_resolved is high
mem_raddr_valid  output  1  memory read request
mem_raddr  output  32  line-aligned read address
mem_rready  input  1  memory accepts read request this cycle
mem_rdata  input  LINE_BITS  memory read data
mem_rdata_valid  input  1  mem_rdata valid
mem_waddr_valid  output  1  memory write request
mem_waddr  output  32  line-aligned write address
mem_wdata  output  LINE_BITS  write data
mem_wmask  output  MASK_BITS  byte enables
mem_wready  input  1  memory accepts write this cycle
grant  output  2  one-hot current owner, 0 when IDLE
timeout_err  output  1  sticky error, cleared only by rst

Behaviour:
- Reset (rst high at clk edge): state IDLE, all outputs 0, round-robin pointer = client 0 preferred. Reset mid-transaction abandons it; no repair_resolved is issued; in-flight mem_rdata_valid after reset is ignored.
- A client requests if read_repair_request[i] | write_miss_repair[i]; write_miss_repair takes precedence if both set.
- IDLE: if any request, grant preferred client if requesting, else the other; latch address/data/mask and op into internal registers; grant updates next cycle. Next state WR_REQ for writeback op, else RD_REQ. Client inputs are not sampled again until IDLE.
- WR_REQ: mem_waddr_valid=1 with latched wb_addr (bits [4:0] forced 0), wb_data, wb_mask. Leave on cycle where mem_wready=1 -> RD_REQ.
- RD_REQ: mem_raddr_valid=1, mem_raddr = latched missed_addr with [4:0]=0. On mem_rready=1 -> RD_WAIT; watchdog cleared.
- RD_WAIT: watchdog increments each cycle. On mem_rdata_valid=1: capture mem_rdata into fill_data -> DONE. If watchdog reaches TIMEOUT with no data: set timeout_err, -> DONE with fill_data = 0.
- DONE (1 cycle): repair_resolved[granted]=1, fill_data stable; round-robin pointer set to the other client; -> IDLE; grant cleared.
- Minimum latency request to resolve, zero-wait memory (ready=1, data the cycle after acceptance): fill 4 cycles, writeback+fill 5 cycles.
- Valid outputs are registered; mem_*_valid held stable with constant payload until accepted.
- mem_rdata_valid outside RD_WAIT is ignored. Simultaneous requests alternate strictly; single requester is granted back-to-back without penalty beyond the IDLE cycle.
- Client must drop its request in the cycle after repair_resolved; a request still high in IDLE is treated as new.

Test Plan:
- Single fill: client 1 read_repair_request, missed_addr=0x0000_1234, mem ready immediately, data=0xA5.. -> mem_raddr=0x0000_1220, repair_resolved=2'b10 4 cycles after request, fill_data=0xA5..
- Writeback+fill: client 1 write_miss_repair, wb_addr=0x0000_8040, mask=0xFFFF_FFFF, mem_wready delayed 3 cycles -> mem_waddr_valid held 4 cycles with constant payload, then read of missed_addr, resolve at cycle 8.
- Contention: both clients request continuously from reset -> grants 01,10,01,10; each repair_resolved pulses exactly once per transaction.
- Timeout: TIMEOUT=15, mem never asserts rdata_valid -> timeout_err=1 after 15 RD_WAIT cycles, repair_resolved pulses with fill_data=0, error stays set until rst.
- Reset mid-op: assert rst in RD_WAIT, later stray mem_rdata_valid -> all outputs 0, no repair_resolved, next request served normally.
- Stray data: mem_rdata_valid pulsed in IDLE -> no state change, no output.
